// File: rtl/pe_busif.sv
// pe_busif: memory-side bus interface for the processing element.
// It watches the PE fetch address and runs one req/ack memory read each time
// the address changes, or when no word has been fetched since reset. The word
// comes back to the PE with a one-cycle valid pulse.
// Optional feature macro: BUSIF_TIMEOUT_EN. It adds a WAIT timeout that aborts
// a hung read, returns an all-ones word and sets a sticky err_o.
//
// Handshake: mem_req_o is raised together with a registered mem_ad_o. Both stay
// stable until the edge that samples mem_ack_i=1 (data taken from mem_data_i in
// that same cycle) or until an abort. pe_valid_o is a single-cycle pulse. There
// is no back-pressure from the PE.
module pe_busif #(
   parameter int AD_LEN    = 32,
   parameter int BUS_WIDTH = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [AD_LEN-1:0]    pe_ad_i,
   output logic [BUS_WIDTH-1:0] pe_data_o,
   output logic                 pe_valid_o,
   output logic                 mem_req_o,
   output logic [AD_LEN-1:0]    mem_ad_o,
   input  logic                 mem_ack_i,
   input  logic [BUS_WIDTH-1:0] mem_data_i,
   output logic                 err_o,
   output logic                 dbg_state_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic [AD_LEN-1:0]    mem_ad_q, mem_ad_d;
   logic [BUS_WIDTH-1:0] pe_data_q, pe_data_d;
   logic                 pe_valid_q, pe_valid_d;
   logic [AD_LEN-1:0]    last_ad_q, last_ad_d;
   logic                 have_data_q, have_data_d;
   logic                 need_req;
   logic                 abort;

   // A new read is needed if nothing has been fetched yet or the PE moved on
   assign need_req = !have_data_q || (pe_ad_i != last_ad_q);

`ifdef BUSIF_TIMEOUT_EN
   localparam int CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   // Abort only if no ack arrives in the cycle the counter reaches TIMEOUT
   assign abort = (state_q == S_WAIT) && !mem_ack_i && (cnt_q == CntMax);

   // WAIT cycle counter (saturating) and sticky error next-state
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q | abort;
      if (state_q == S_IDLE && need_req) begin
         cnt_d = '0;
      end else if (state_q == S_WAIT && !mem_ack_i && cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter and error flag registers
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic unused_timeout;

   assign abort          = 1'b0;
   assign err_o          = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: leave IDLE on a needed read, leave WAIT on ack or abort
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (need_req) state_d = S_WAIT;
         S_WAIT: if (mem_ack_i || abort) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; ack in IDLE is deliberately ignored
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_ad_d    = mem_ad_q;
      pe_data_d   = pe_data_q;
      pe_valid_d  = 1'b0;
      last_ad_d   = last_ad_q;
      have_data_d = have_data_q;
      case (state_q)
         S_IDLE: begin
            if (need_req) begin
               mem_ad_d  = pe_ad_i;
               mem_req_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_ack_i) begin
               pe_data_d   = mem_data_i;
               last_ad_d   = mem_ad_q;
               have_data_d = 1'b1;
               pe_valid_d  = 1'b1;
               mem_req_d   = 1'b0;
            end else if (abort) begin
               // Aborted address is recorded so it is not retried until it changes
               pe_data_d   = '1;
               last_ad_d   = mem_ad_q;
               have_data_d = 1'b1;
               pe_valid_d  = 1'b1;
               mem_req_d   = 1'b0;
            end
         end
         default: begin
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         mem_req_q   <= 1'b0;
         mem_ad_q    <= '0;
         pe_data_q   <= '0;
         pe_valid_q  <= 1'b0;
         last_ad_q   <= '0;
         have_data_q <= 1'b0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_ad_q    <= mem_ad_d;
         pe_data_q   <= pe_data_d;
         pe_valid_q  <= pe_valid_d;
         last_ad_q   <= last_ad_d;
         have_data_q <= have_data_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_ad_o    = mem_ad_q;
   assign pe_data_o   = pe_data_q;
   assign pe_valid_o  = pe_valid_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_busif.sv
// tb_pe_busif: self-checking bench for pe_busif (32-bit bus, TIMEOUT=8).
// Timeout scenarios are exercised when BUSIF_TIMEOUT_EN is defined; otherwise
// a long ack delay checks that WAIT never aborts and err_o stays low.
module tb_pe_busif;

   localparam int TO = 8;

   logic        clk_i;
   logic        reset_i;
   logic [31:0] pe_ad_i;
   logic [31:0] pe_data_o;
   logic        pe_valid_o;
   logic        mem_req_o;
   logic [31:0] mem_ad_o;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic        err_o;
   logic        dbg_state_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_word;
   logic        prev_valid = 1'b0;

   typedef struct {
      logic [31:0] ad;
      logic [31:0] data;
      int          delay;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs[6];

   pe_busif #(
      .AD_LEN    (32),
      .BUS_WIDTH (32),
      .TIMEOUT   (TO)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .pe_ad_i     (pe_ad_i),
      .pe_data_o   (pe_data_o),
      .pe_valid_o  (pe_valid_o),
      .mem_req_o   (mem_req_o),
      .mem_ad_o    (mem_ad_o),
      .mem_ack_i   (mem_ack_i),
      .mem_data_i  (mem_data_i),
      .err_o       (err_o),
      .dbg_state_o (dbg_state_o)
   );

   // Clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every valid pulse pops one expected word
   always @(negedge clk_i) begin
      if (reset_i && pe_valid_o) begin
         check("valid_back_to_back", {31'b0, prev_valid}, 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid with data %h, expected no pulse", pe_data_o);
         end else begin
            check("rd_data", pe_data_o, exp_q.pop_front());
         end
      end
      prev_valid = pe_valid_o;
   end

   // Wait one cycle after a request edge and check the request is visible
   task automatic check_req(input logic [31:0] ad);
      @(negedge clk_i);
      check("req_high", {31'b0, mem_req_o}, 32'd1);
      check("req_addr", mem_ad_o, ad);
   endtask

   // Hold ack low for 'delay' cycles, then ack once and check the return pulse
   task automatic finish_txn(input logic [31:0] ad, input logic [31:0] data,
                             input logic [31:0] exp, input int delay);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk_i);
         check("wait_req", {31'b0, mem_req_o}, 32'd1);
         check("wait_addr", mem_ad_o, ad);
         check("wait_no_valid", {31'b0, pe_valid_o}, 32'd0);
      end
      mem_ack_i  = 1'b1;
      mem_data_i = data;
      exp_q.push_back(exp);
      @(negedge clk_i);
      mem_ack_i  = 1'b0;
      mem_data_i = $urandom;
      check("valid_pulse", {31'b0, pe_valid_o}, 32'd1);
      check("req_drop", {31'b0, mem_req_o}, 32'd0);
      last_word = exp;
   endtask

   task automatic do_txn(input logic [31:0] ad, input logic [31:0] data, input int delay);
      pe_ad_i = ad;
      check_req(ad);
      finish_txn(ad, data, data, delay);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         check("idle_no_req", {31'b0, mem_req_o}, 32'd0);
         check("idle_data_hold", pe_data_o, last_word);
      end
   endtask

   initial begin
      logic [31:0] w;

      // Vector table: address, memory word, ack delay, expected returned word
      vecs[0] = '{32'h0000_0200, 32'h0, 0, 32'h0};
      vecs[1] = '{32'h0000_0204, 32'h0, 1, 32'h0};
      vecs[2] = '{32'h0000_0300, 32'h0, 3, 32'h0};
      vecs[3] = '{32'h0000_0000, 32'h0, 0, 32'h0};
      vecs[4] = '{32'hFFFF_FFFC, 32'h0, 2, 32'h0};
      vecs[5] = '{32'h0000_0208, 32'h0, 6, 32'h0};
      for (int i = 0; i < 6; i++) begin
         vecs[i].data     = $urandom;
         vecs[i].exp_word = vecs[i].data;
         if (vecs[i].delay == 0 && i == 3) vecs[i].delay = $urandom_range(0, 5);
      end

      // Reset with the first fetch address already presented
      reset_i    = 1'b0;
      pe_ad_i    = 32'h0000_0100;
      mem_ack_i  = 1'b0;
      mem_data_i = 32'h0;
      last_word  = 32'h0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_req", {31'b0, mem_req_o}, 32'd0);
      check("rst_ad", mem_ad_o, 32'h0);
      check("rst_data", pe_data_o, 32'h0);
      check("rst_valid", {31'b0, pe_valid_o}, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      check("rst_state", {31'b0, dbg_state_o}, 32'd0);
      reset_i = 1'b1;

      // First edge after release requests 0x100; ack in the first request cycle
      check_req(32'h0000_0100);
      finish_txn(32'h0000_0100, 32'hCAFE_0100, 32'hCAFE_0100, 0);

      // Constant address: no further requests and data holds
      idle_cycles(20);

      // Table-driven transactions with a few random idle gaps between them
      for (int i = 0; i < 6; i++) begin
         do_txn(vecs[i].ad, vecs[i].data, vecs[i].delay);
         check("vec_word", pe_data_o, vecs[i].exp_word);
         idle_cycles($urandom_range(0, 2));
      end

      // Address moves mid-WAIT: stale word first, then a fresh request
      pe_ad_i = 32'h0000_0100;
      check_req(32'h0000_0100);
      @(negedge clk_i);
      pe_ad_i = 32'h0000_0104;
      finish_txn(32'h0000_0100, 32'h1111_0100, 32'h1111_0100, 4);
      check_req(32'h0000_0104);
      finish_txn(32'h0000_0104, 32'h2222_0104, 32'h2222_0104, 1);
      idle_cycles(3);

`ifdef BUSIF_TIMEOUT_EN
      // Ack in the same cycle the counter hits TIMEOUT: normal completion
      w = $urandom;
      do_txn(32'h0000_0400, w, TO);
      check("ack_at_to_err", {31'b0, err_o}, 32'd0);

      // No ack: abort at the (TO+1)th edge in WAIT
      pe_ad_i = 32'h0000_0500;
      check_req(32'h0000_0500);
      for (int i = 0; i < TO; i++) begin
         @(negedge clk_i);
         check("to_wait_req", {31'b0, mem_req_o}, 32'd1);
         check("to_wait_err", {31'b0, err_o}, 32'd0);
      end
      exp_q.push_back(32'hFFFF_FFFF);
      @(negedge clk_i);
      check("to_req_drop", {31'b0, mem_req_o}, 32'd0);
      check("to_valid", {31'b0, pe_valid_o}, 32'd1);
      check("to_data", pe_data_o, 32'hFFFF_FFFF);
      check("to_err", {31'b0, err_o}, 32'd1);
      last_word = 32'hFFFF_FFFF;
      idle_cycles(10);
      check("to_err_sticky", {31'b0, err_o}, 32'd1);
      w = $urandom;
      do_txn(32'h0000_0504, w, 2);
      check("err_after_ok", {31'b0, err_o}, 32'd1);
`else
      // Without the timeout feature WAIT outlasts TIMEOUT with no abort
      w = $urandom;
      do_txn(32'h0000_0400, w, TO + 12);
      check("no_to_err", {31'b0, err_o}, 32'd0);
`endif

      // Reset during WAIT: request drops asynchronously
      pe_ad_i = 32'h0000_0600;
      check_req(32'h0000_0600);
      @(negedge clk_i);
      #2;
      reset_i = 1'b0;
      #1;
      check("async_req_drop", {31'b0, mem_req_o}, 32'd0);
      check("async_ad", mem_ad_o, 32'h0);
      check("async_data", pe_data_o, 32'h0);
      check("async_valid", {31'b0, pe_valid_o}, 32'd0);
      check("async_err", {31'b0, err_o}, 32'd0);
      last_word = 32'h0;
      @(negedge clk_i);
      mem_ack_i  = 1'b1;
      mem_data_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      reset_i = 1'b1;
      // Stray ack is sampled in IDLE: no pulse, fresh request for 0x600
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      check("stray_ack_no_valid", {31'b0, pe_valid_o}, 32'd0);
      check("post_rst_req", {31'b0, mem_req_o}, 32'd1);
      check("post_rst_ad", mem_ad_o, 32'h0000_0600);
      finish_txn(32'h0000_0600, 32'h6666_0600, 32'h6666_0600, 2);
      idle_cycles(4);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
